// File: rtl/voice_allocator.sv
// voice_allocator
//   Polyphonic note scheduler. Accepts note-on/note-off events over a
//   valid/ready handshake, maps each note onto one of NUM_VOICES voices,
//   drives per-voice frequency codes and gates, and steals the
//   least-recently-allocated voice when every voice is held.
//
// Ports
//   Clk          system clock
//   Reset        synchronous, active-high reset
//   ev_valid     event present
//   ev_ready     allocator can accept an event (FSM idle)
//   ev_on        1 = note-on, 0 = note-off
//   ev_note      note code
//   all_off      panic: release all voices, abort any pending event
//   key_on       per-voice gate, bit v drives voice v
//   freq         packed note codes, voice v uses [v*NOTE_W +: NOTE_W]
//   steal_pulse  one-cycle strobe when a steal starts
//   busy         ~ev_ready
module voice_allocator #(
  parameter int NUM_VOICES = 8,
  parameter int NOTE_W     = 7,
  parameter int STEAL_GAP  = 4
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         ev_valid,
  output logic                         ev_ready,
  input  logic                         ev_on,
  input  logic [NOTE_W-1:0]            ev_note,
  input  logic                         all_off,
  output logic [NUM_VOICES-1:0]        key_on,
  output logic [NUM_VOICES*NOTE_W-1:0] freq,
  output logic                         steal_pulse,
  output logic                         busy
);

  localparam int RW = $clog2(NUM_VOICES);
  localparam int CW = (STEAL_GAP > 1) ? $clog2(STEAL_GAP) : 1;

  typedef enum logic [1:0] {IDLE, DECIDE, GAP} state_t;

  state_t              r_state;
  logic                r_on;
  logic [NOTE_W-1:0]   r_note;
  logic [NUM_VOICES-1:0] r_key_on;
  logic [NOTE_W-1:0]   r_freq [NUM_VOICES];
  logic [RW-1:0]       r_rank [NUM_VOICES];
  logic [RW-1:0]       r_victim;
  logic [CW-1:0]       r_cnt;
  logic                r_steal;

  logic                w_match_hit;
  logic [RW-1:0]       w_match_idx;
  logic                w_free_hit;
  logic [RW-1:0]       w_free_idx;
  logic [RW-1:0]       w_lru_idx;
  logic [RW-1:0]       w_touch_idx;
  logic [RW-1:0]       w_rank_next [NUM_VOICES];

  assign ev_ready    = (r_state == IDLE);
  assign busy        = ~ev_ready;
  assign key_on      = r_key_on;
  assign steal_pulse = r_steal;

  always_comb begin
    freq = '0;
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      freq[v*NOTE_W +: NOTE_W] = r_freq[v];
    end
  end

  // Priority searches: lowest-index held match, lowest-index free voice,
  // and the voice holding the oldest rank.
  always_comb begin
    w_match_hit = 1'b0;
    w_match_idx = '0;
    w_free_hit  = 1'b0;
    w_free_idx  = '0;
    w_lru_idx   = '0;
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      if (!w_match_hit && r_key_on[v] && (r_freq[v] == r_note)) begin
        w_match_hit = 1'b1;
        w_match_idx = RW'(v);
      end
      if (!w_free_hit && !r_key_on[v]) begin
        w_free_hit = 1'b1;
        w_free_idx = RW'(v);
      end
      if (r_rank[v] == RW'(NUM_VOICES - 1)) begin
        w_lru_idx = RW'(v);
      end
    end
  end

  // Rank update for whichever voice the current state would touch; only
  // committed when the FSM actually allocates or retriggers.
  always_comb begin
    if (r_state == GAP)  w_touch_idx = r_victim;
    else if (w_match_hit) w_touch_idx = w_match_idx;
    else                  w_touch_idx = w_free_idx;
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      if (RW'(v) == w_touch_idx)
        w_rank_next[v] = '0;
      else if (r_rank[v] < r_rank[w_touch_idx])
        w_rank_next[v] = r_rank[v] + 1'b1;
      else
        w_rank_next[v] = r_rank[v];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state  <= IDLE;
      r_on     <= 1'b0;
      r_note   <= '0;
      r_key_on <= '0;
      r_victim <= '0;
      r_cnt    <= '0;
      r_steal  <= 1'b0;
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        r_freq[v] <= '0;
        r_rank[v] <= RW'(v);
      end
    end else begin
      r_steal <= 1'b0;
      if (all_off) begin
        // Panic wins over any FSM action; freq and ranks are kept.
        r_key_on <= '0;
        r_state  <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (ev_valid) begin
              r_on    <= ev_on;
              r_note  <= ev_note;
              r_state <= DECIDE;
            end
          end
          DECIDE: begin
            r_state <= IDLE;
            if (!r_on) begin
              if (w_match_hit) r_key_on[w_match_idx] <= 1'b0;
            end else if (w_match_hit) begin
              r_rank <= w_rank_next;
            end else if (w_free_hit) begin
              r_freq[w_free_idx]   <= r_note;
              r_key_on[w_free_idx] <= 1'b1;
              r_rank               <= w_rank_next;
            end else begin
              r_key_on[w_lru_idx] <= 1'b0;
              r_victim            <= w_lru_idx;
              r_steal             <= 1'b1;
              r_cnt               <= CW'(STEAL_GAP - 1);
              r_state             <= GAP;
            end
          end
          GAP: begin
            if (r_cnt == '0) begin
              r_freq[r_victim]   <= r_note;
              r_key_on[r_victim] <= 1'b1;
              r_rank             <= w_rank_next;
              r_state            <= IDLE;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
Polyphonic note scheduler that sits between the Nios-side note-event source and the 8 Voice instances. It accepts note-on/note-off events over a valid/ready handshake and maps each note onto a voice. It drives each voice's frequency code (F_in) and key_on, and steals the least-recently-allocated voice when all voices are held. It replaces the per-voice FREQn/KEYn registers as the driver of the voice bank; the Arpeggiator then consumes key_on as it does KEYn today.

Parameters:
NUM_VOICES, 8, number of voices; power of 2, 2..16.
NOTE_W, 7, width of the note/frequency code; matches Voice F_in.
STEAL_GAP, 4, cycles (>=1) that a stolen voice's key_on is held low before the new note is applied, so the downstream ADSR sees a release edge.

Ports:
Clk  in  1  system clock (CLOCK_50 domain).
Reset  in  1  synchronous, active-high reset.
ev_valid  in  1  event present.
ev_ready  out  1  allocator can accept an event.
ev_on  in  1  1 = note-on, 0 = note-off.
ev_note  in  NOTE_W  note code.
all_off  in  1  panic: release all voices.
key_on  out  NUM_VOICES  per-voice gate; bit v drives voice v.
freq  out  NUM_VOICES*NOTE_W  packed note codes; voice v uses bits [v*NOTE_W +: NOTE_W].
steal_pulse  out  1  one-cycle strobe when a steal is started.
busy  out  1  ~ev_ready.

Behaviour:
- Reset values: key_on=0, freq=0, steal_pulse=0, state=IDLE, rank[v]=v.
- ev_ready=(state==IDLE), so ev_ready is 1 in the first cycle after Reset.
- FSM states: IDLE, DECIDE, GAP.
- IDLE: when ev_valid&ev_ready at edge k, latch ev_on/ev_note and go to DECIDE. Outputs update at edge k+1; ev_ready is high again after k+1. Throughput is 1 event per 2 cycles.
- DECIDE, match rule: match = lowest v with key_on[v]=1 and freq[v]==note.
  - note-off, match found: key_on[v]<=0; go to IDLE.
  - note-off, no match: no change; go to IDLE. The event is still consumed.
  - note-on, match found (retrigger): no output change; touch(v); go to IDLE.
  - note-on, no match, free voice exists: v = lowest index with key_on=0; freq[v]<=note, key_on[v]<=1, touch(v); go to IDLE.
  - note-on, no match, all voices held: victim = voice with rank NUM_VOICES-1. key_on[victim]<=0; steal_pulse<=1 for one cycle; load gap counter with STEAL_GAP-1; go to GAP. freq[victim] is unchanged during GAP.
- GAP: counter decrements each cycle. At counter==0: freq[victim]<=note, key_on[victim]<=1, touch(victim); go to IDLE. The victim's key_on is therefore low for exactly STEAL_GAP cycles.
- touch(v) (LRU):
  - every voice with rank < rank[v] increments rank; then rank[v]<=0.
  - ranks always form a permutation of 0..NUM_VOICES-1.
  - note-off does not change ranks.
- all_off: has priority over every FSM action in the same cycle.
  - key_on<=0 and state<=IDLE; any event in DECIDE or GAP is dropped.
  - freq and ranks are retained; steal_pulse<=0.
- Reset mid-operation (any state): all reset values apply at the next edge.
- Duplicate held notes cannot arise, because a note-on for a held note retriggers instead of allocating.
- Note codes are compared as unsigned, full NOTE_W bits. freq=0 is a legal note.

Test Plan:
1. Reset; accept note-on 60 at edge k -> after edge k+1: key_on=8'h01, freq[0]=60, ev_ready=1. Hold ev_valid for a second event: it is accepted at edge k+2, not k+1.
2. Note-on 60..67 sequentially -> key_on=8'hFF, freq[v]=60+v. Then note-on 70 -> steal_pulse high for 1 cycle, key_on[0]=0 for 4 cycles, then freq[0]=70 and key_on=8'hFF. Next note-on 71 steals voice 1.
3. From 8 held voices (60..67): note-off 62 -> key_on=8'hFB. Note-on 80 -> voice 2 gets 80 with no steal_pulse. Note-off 99 (unmatched) -> no change, event consumed.
4. Retrigger: 8 held voices (60..67), re-send note-on 60 -> no output change. Next note-on 90 steals voice 1, not voice 0.
5. Assert all_off during GAP (cycle 2 of 4) -> key_on=0 next edge, ev_ready=1, freq[victim] still old note, no later apply.
6. Assert Reset during GAP -> key_on=0, freq=0, ranks=index. Note-on 50 then lands on voice 0.
